// File: rtl/mem_resp_pkg.sv
// Shared geometry, FSM encoding and init pattern for the line memory responder.
// No logic; no latency.
// Not applicable: package only.
package mem_resp_pkg;

    localparam int ADDR_WIDTH     = 32;
    localparam int LINE_SIZE      = 32;
    localparam int LINE_BITS      = LINE_SIZE * 8;
    localparam int DEPTH          = 1024;
    localparam int OFFSET_BITS    = $clog2(LINE_SIZE);
    localparam int INDEX_BITS     = $clog2(DEPTH);
    localparam int WORDS_PER_LINE = LINE_SIZE / 4;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        IDLE   = 2'd1,
        ACCESS = 2'd2,
        TURN   = 2'd3
    } state_t;

    // Every 32-bit word of a freshly initialised line carries its own line index.
    function automatic logic [LINE_BITS-1:0] init_pattern(input logic [INDEX_BITS-1:0] idx);
        logic [31:0] word;
        word = 32'(idx);
        return {WORDS_PER_LINE{word}};
    endfunction

endpackage

// File: rtl/line_store.sv
// Single-port DEPTH x LINE_BITS line array: synchronous write, registered read.
// Latency: write lands on the enable edge; read data appears one edge after enable.
// Backpressure: none; exactly one access per enabled cycle.
module line_store
    import mem_resp_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  we,
    input  logic [INDEX_BITS-1:0] idx,
    input  logic [LINE_BITS-1:0]  wdata,
    output logic [LINE_BITS-1:0]  rdata
);

    logic [LINE_BITS-1:0] mem_q [DEPTH];
    logic [LINE_BITS-1:0] rdata_d;
    logic [LINE_BITS-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en && we) begin
            mem_q[idx] <= wdata;
        end
    end

    // Read data is held until the next read so the responder can present it stably.
    always_comb begin
        rdata_d = rdata_q;
        if (en && !we) begin
            rdata_d = mem_q[idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/line_memory_responder.sv
// Line-granular main-memory responder: self-initialises, then serves one read/write at a time.
// Latency: mem_ready pulses READ_LATENCY / WRITE_LATENCY edges after the accept edge.
// Backpressure: level requests held until mem_ready; one request per LATENCY+1 cycles.
module line_memory_responder
    import mem_resp_pkg::*;
#(
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [LINE_BITS-1:0]  mem_write_data,
    output logic [LINE_BITS-1:0]  mem_read_data,
    output logic                  mem_ready,
    output logic                  init_done,
    output logic                  busy,
    output logic                  proto_err
);

    localparam int LAT_MAX = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int LAT_W   = $clog2(LAT_MAX + 1);

    state_t                state_q, state_d;
    logic [INDEX_BITS-1:0] init_idx_q, init_idx_d;
    logic [LAT_W-1:0]      lat_cnt_q, lat_cnt_d;
    logic [INDEX_BITS-1:0] idx_q, idx_d;
    logic                  op_write_q, op_write_d;
    logic [LINE_BITS-1:0]  wdata_q, wdata_d;
    logic                  mem_ready_q, mem_ready_d;
    logic                  init_done_q, init_done_d;
    logic                  proto_err_q, proto_err_d;

    logic                  st_en;
    logic                  st_we;
    logic [INDEX_BITS-1:0] st_idx;
    logic [LINE_BITS-1:0]  st_wdata;
    logic                  req;

    // Offset and aliasing upper bits are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_addr[ADDR_WIDTH-1:OFFSET_BITS+INDEX_BITS],
                                mem_addr[OFFSET_BITS-1:0]};

    assign req = mem_read | mem_write;

    always_comb begin
        state_d     = state_q;
        init_idx_d  = init_idx_q;
        lat_cnt_d   = lat_cnt_q;
        idx_d       = idx_q;
        op_write_d  = op_write_q;
        wdata_d     = wdata_q;
        mem_ready_d = 1'b0;
        init_done_d = init_done_q;
        proto_err_d = proto_err_q;
        st_en       = 1'b0;
        st_we       = 1'b0;
        st_idx      = idx_q;
        st_wdata    = wdata_q;

        case (state_q)
            INIT: begin
                st_en      = 1'b1;
                st_we      = 1'b1;
                st_idx     = init_idx_q;
                st_wdata   = init_pattern(init_idx_q);
                init_idx_d = init_idx_q + INDEX_BITS'(1);
                if (init_idx_q == INDEX_BITS'(DEPTH - 1)) begin
                    state_d     = IDLE;
                    init_done_d = 1'b1;
                end
            end
            // TURN is the mem_ready cycle; a request still held at its closing edge is new.
            IDLE, TURN: begin
                if (req) begin
                    idx_d      = mem_addr[OFFSET_BITS +: INDEX_BITS];
                    op_write_d = mem_write;
                    wdata_d    = mem_write_data;
                    lat_cnt_d  = mem_write ? LAT_W'(WRITE_LATENCY - 1) : LAT_W'(READ_LATENCY - 1);
                    state_d    = ACCESS;
                    if (mem_read && mem_write) begin
                        proto_err_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (lat_cnt_q == '0) begin
                    st_en       = 1'b1;
                    st_we       = op_write_q;
                    mem_ready_d = 1'b1;
                    state_d     = TURN;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT;
            init_idx_q  <= '0;
            lat_cnt_q   <= '0;
            idx_q       <= '0;
            op_write_q  <= 1'b0;
            wdata_q     <= '0;
            mem_ready_q <= 1'b0;
            init_done_q <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_idx_q  <= init_idx_d;
            lat_cnt_q   <= lat_cnt_d;
            idx_q       <= idx_d;
            op_write_q  <= op_write_d;
            wdata_q     <= wdata_d;
            mem_ready_q <= mem_ready_d;
            init_done_q <= init_done_d;
            proto_err_q <= proto_err_d;
        end
    end

    line_store u_store (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (st_en),
        .we    (st_we),
        .idx   (st_idx),
        .wdata (st_wdata),
        .rdata (mem_read_data)
    );

    assign mem_ready = mem_ready_q;
    assign init_done = init_done_q;
    assign proto_err = proto_err_q;
    assign busy      = (state_q != IDLE);

endmodule
